// File: rtl/sc_et_sched.sv
// rtl/sc_et_sched.sv - Early-termination stochastic-computing job controller
//
// Accepts one job at a time. Each job is a set of operands, a precision cap
// and a combine op (AND/OR). The controller finds the shortest exact stream
// length from the operands' trailing zeros. It then steps one shared counter
// through that length, emitting the correlated comparator bits and
// accumulating the combined stream. At the end it returns the scaled result.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   job handshake (ready only while idle)
//   req_bx            operands, operand i = req_bx[i*WIDTH +: WIDTH]
//   req_prec          precision cap in bits (clamped to WIDTH)
//   req_op            0 = AND (min), 1 = OR (max)
//   abort             cancel a job in SETUP or RUN
//   bits_valid, bits  registered per-operand stream bits during RUN
//   res_valid/ready   result handshake
//   res_value         ones count scaled back to WIDTH-bit magnitude
//   res_len           stream length used (2^P)
//   busy              controller not idle
module sc_et_sched #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [WIDTH*NUM_INPUTS-1:0]     req_bx,
  input  logic [$clog2(WIDTH+1)-1:0]      req_prec,
  input  logic                            req_op,
  input  logic                            abort,
  output logic                            bits_valid,
  output logic [NUM_INPUTS-1:0]           bits,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [WIDTH:0]                  res_value,
  output logic [WIDTH:0]                  res_len,
  output logic                            busy
);
  localparam int PW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [WIDTH*NUM_INPUTS-1:0]   bt_q, bt_d;
  logic [PW-1:0]                 p_q, p_d;
  logic                          op_q, op_d;
  logic [WIDTH-1:0]              cnt_q, cnt_d;
  logic [WIDTH:0]                acc_q, acc_d;
  logic [NUM_INPUTS-1:0]         bits_q, bits_d;
  logic                          bits_valid_q, bits_valid_d;
  logic [WIDTH:0]                res_value_q, res_value_d;
  logic [WIDTH:0]                res_len_q, res_len_d;

  logic [PW-1:0]                 pcap;
  logic [WIDTH:0]                one_sh;
  logic [WIDTH-1:0]              keep_mask;
  logic [PW-1:0]                 p_setup;
  logic [WIDTH:0]                len;
  logic                          last;
  logic                          comb_bit;
  logic [WIDTH:0]                acc_sum;

  // Comparator bank: all operands share one compare value, which is what
  // keeps the streams correlated (thermometer-coded against the counter).
  function automatic logic [NUM_INPUTS-1:0] cmp_bits(
    input logic [WIDTH-1:0]            cnt,
    input logic [PW-1:0]               p,
    input logic [WIDTH*NUM_INPUTS-1:0] bt
  );
    logic [WIDTH-1:0]      c;
    logic [NUM_INPUTS-1:0] r;
    c = cnt << (PW'(WIDTH) - p);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      r[i] = c < bt[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Truncation mask: clear the low WIDTH-P_cap bits of every operand.
  always_comb begin
    pcap      = (req_prec > PW'(WIDTH)) ? PW'(WIDTH) : req_prec;
    one_sh    = (WIDTH+1)'(1) << (PW'(WIDTH) - pcap);
    keep_mask = ~(one_sh[WIDTH-1:0] - WIDTH'(1));
  end

  // Shortest exact length: P = WIDTH - min trailing zeros (zero operand = WIDTH).
  always_comb begin
    int tz;
    int min_tz;
    min_tz = WIDTH;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      tz = WIDTH;
      for (int j = WIDTH-1; j >= 0; j--) begin
        if (bt_q[i*WIDTH + j]) tz = j;
      end
      if (tz < min_tz) min_tz = tz;
    end
    p_setup = PW'(WIDTH - min_tz);
  end

  always_comb begin
    len      = (WIDTH+1)'(1) << p_q;
    last     = ({1'b0, cnt_q} == (len - (WIDTH+1)'(1)));
    comb_bit = op_q ? (|bits_q) : (&bits_q);
    acc_sum  = acc_q + {{WIDTH{1'b0}}, comb_bit};
  end

  always_comb begin
    state_d      = state_q;
    bt_d         = bt_q;
    p_d          = p_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    bits_d       = '0;
    bits_valid_d = 1'b0;
    res_value_d  = res_value_q;
    res_len_d    = res_len_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          bt_d    = req_bx & {NUM_INPUTS{keep_mask}};
          op_d    = req_op;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          p_d          = p_setup;
          cnt_d        = '0;
          acc_d        = '0;
          bits_d       = cmp_bits('0, p_setup, bt_q);
          bits_valid_d = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // bits_q is the bit on the wire this cycle; it is folded into acc
        // while the next cycle's bits are precomputed from cnt+1.
        if (abort) begin
          state_d = S_IDLE;
        end else if (last) begin
          acc_d       = acc_sum;
          res_value_d = acc_sum << (PW'(WIDTH) - p_q);
          res_len_d   = len;
          state_d     = S_DONE;
        end else begin
          acc_d        = acc_sum;
          cnt_d        = cnt_q + WIDTH'(1);
          bits_d       = cmp_bits(cnt_q + WIDTH'(1), p_q, bt_q);
          bits_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bt_q         <= '0;
      p_q          <= '0;
      op_q         <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      bits_q       <= '0;
      bits_valid_q <= 1'b0;
      res_value_q  <= '0;
      res_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      bt_q         <= bt_d;
      p_q          <= p_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      bits_q       <= bits_d;
      bits_valid_q <= bits_valid_d;
      res_value_q  <= res_value_d;
      res_len_q    <= res_len_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign res_valid  = (state_q == S_DONE);
  assign bits       = bits_q;
  assign bits_valid = bits_valid_q;
  assign res_value  = res_value_q;
  assign res_len    = res_len_q;

endmodule
